// File: rtl/abcd_seq_checker.sv
// abcd_seq_checker
//   Hardware checker for the temporal sequence a ##1 b ##2 c ##2 d. Each
//   enabled clock starts a new attempt, so several attempts can be in flight
//   at once. Every attempt ends in exactly one pass or one fail. Events are
//   registered one-cycle pulses, and running totals are kept in saturating
//   counters.
//
// Ports
//   clk, rst_n    rising-edge clock and synchronous active-low reset
//   en            start a new attempt this cycle
//   a, b, c, d    sequence elements at offsets 0, 1, 3 and 5
//   pass          pulse: an attempt completed successfully
//   pass_start    start timestamp of the last passing attempt (held)
//   fail_vec      per-check fail pulses, [0]=a [1]=b [2]=c [3]=d
//   fail_start    start timestamp of the oldest attempt that failed (held)
//   pass_count    saturating count of passes
//   fail_count    saturating count of failed attempts
//   cyc           free-running cycle timestamp (wraps)
module abcd_seq_checker #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             pass,
  output logic [TS_W-1:0]  pass_start,
  output logic [3:0]       fail_vec,
  output logic [TS_W-1:0]  fail_start,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [TS_W-1:0]  cyc
);

  // Attempt pipeline: vN is set when an attempt of age N is still alive.
  // sN holds the start stamp of that attempt.
  logic            v1, v2, v3, v4, v5;
  logic [TS_W-1:0] s1, s2, s3, s4, s5;

  logic            pass_nxt;
  logic [3:0]      fail_nxt;
  logic [TS_W-1:0] fail_start_nxt;
  logic [2:0]      fail_pop;
  logic [CNT_W:0]  fail_sum;
  logic [CNT_W:0]  pass_sum;

  always_comb begin
    fail_nxt = {v5 & ~d, v3 & ~c, v1 & ~b, en & ~a};
    pass_nxt = v5 & d;

    // The highest set fail bit belongs to the oldest attempt.
    fail_start_nxt = cyc;
    if (fail_nxt[3])      fail_start_nxt = s5;
    else if (fail_nxt[2]) fail_start_nxt = s3;
    else if (fail_nxt[1]) fail_start_nxt = s1;

    fail_pop = 3'(fail_nxt[0]) + 3'(fail_nxt[1]) + 3'(fail_nxt[2]) + 3'(fail_nxt[3]);
    // Add one bit of headroom. If that top bit gets set, the counter clamps.
    fail_sum = {1'b0, fail_count} + (CNT_W+1)'(fail_pop);
    pass_sum = {1'b0, pass_count} + (CNT_W+1)'(pass_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc        <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      v4         <= 1'b0;
      v5         <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      s4         <= '0;
      s5         <= '0;
      pass       <= 1'b0;
      pass_start <= '0;
      fail_vec   <= '0;
      fail_start <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      cyc <= cyc + 1'b1;

      v1 <= en & a;
      s1 <= cyc;
      v2 <= v1 & b;
      s2 <= s1;
      v3 <= v2;
      s3 <= s2;
      v4 <= v3 & c;
      s4 <= s3;
      v5 <= v4;
      s5 <= s4;

      pass     <= pass_nxt;
      fail_vec <= fail_nxt;
      if (pass_nxt)  pass_start <= s5;
      if (|fail_nxt) fail_start <= fail_start_nxt;

      pass_count <= pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
      fail_count <= fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_abcd_seq_checker.sv
// tb_abcd_seq_checker
//   Directed scenarios for abcd_seq_checker. Each scenario pushes its
//   hand-computed pass/fail events into a queue. A monitor pops one entry
//   whenever the DUT shows pass or a nonzero fail_vec, and compares it,
//   including the cyc value at which the event was expected. Narrow counter
//   and timestamp widths let the bench reach saturation and wrap quickly.
module tb_abcd_seq_checker;

  localparam int unsigned CW = 8;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic          pass;
  logic [TW-1:0] pass_start, fail_start, cyc;
  logic [3:0]    fail_vec;
  logic [CW-1:0] pass_count, fail_count;

  abcd_seq_checker #(.CNT_W(CW), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .d(d),
    .pass(pass), .pass_start(pass_start), .fail_vec(fail_vec),
    .fail_start(fail_start), .pass_count(pass_count),
    .fail_count(fail_count), .cyc(cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          p;
    logic [TW-1:0] ps;
    logic [3:0]    fv;
    logic [TW-1:0] fs;
    logic [TW-1:0] cy;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic p, input logic [TW-1:0] ps, input logic [3:0] fv,
                      input logic [TW-1:0] fs, input logic [TW-1:0] cy);
    ev_t e;
    e.p = p; e.ps = ps; e.fv = fv; e.fs = fs; e.cy = cy;
    q.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (pass || fail_vec != 4'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {27'b0, pass, fail_vec}, 32'b0);
        end else begin
          e = q.pop_front();
          chk("event_cyc", 32'(cyc), 32'(e.cy));
          chk("event_pass", 32'(pass), 32'(e.p));
          chk("event_fail_vec", 32'(fail_vec), 32'(e.fv));
          if (e.p)          chk("event_pass_start", 32'(pass_start), 32'(e.ps));
          if (e.fv != 4'b0) chk("event_fail_start", 32'(fail_start), 32'(e.fs));
        end
      end
    end
  end

  // Drive one cycle of inputs (called at a falling edge), then wait one cycle.
  task automatic step(input logic e_i, input logic a_i, input logic b_i,
                      input logic c_i, input logic d_i);
    en = e_i; a = a_i; b = b_i; c = c_i; d = d_i;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drained(input string name);
    #1;
    chk(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    @(negedge clk);

    // 1: reset state, then cyc counts up from 0.
    do_reset();
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_vec", 32'(fail_vec), 32'd0);
    chk("rst_pass_start", 32'(pass_start), 32'd0);
    chk("rst_fail_start", 32'(fail_start), 32'd0);
    chk("rst_pass_count", 32'(pass_count), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    chk("rst_cyc0", 32'(cyc), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("cyc_count", 32'(cyc), 32'(i));
    end

    // 2: a single passing attempt started at cyc 0.
    do_reset();
    push(1'b1, 8'd0, 4'b0000, 8'd0, 8'd6);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    drained("s2_drained");
    chk("s2_pass_count", 32'(pass_count), 32'd1);
    chk("s2_fail_count", 32'(fail_count), 32'd0);

    // 3: as 2, but c is missing at cyc 3.
    do_reset();
    push(1'b0, 8'd0, 4'b0100, 8'd0, 8'd4);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    drained("s3_drained");
    chk("s3_pass_count", 32'(pass_count), 32'd0);
    chk("s3_fail_count", 32'(fail_count), 32'd1);

    // 4: back-to-back overlapping passes.
    do_reset();
    for (int k = 0; k < 12; k++) push(1'b1, 8'(k), 4'b0000, 8'd0, 8'(k + 6));
    repeat (12) step(1, 1, 1, 1, 1);
    repeat (6) step(0, 0, 1, 1, 1);
    repeat (2) step(0, 0, 0, 0, 0);
    drained("s4_drained");
    chk("s4_pass_count", 32'(pass_count), 32'd12);
    chk("s4_fail_count", 32'(fail_count), 32'd0);

    // 5: simultaneous a and b failures, with fail_start picking the oldest.
    do_reset();
    push(1'b0, 8'd0, 4'b0011, 8'd0, 8'd2);
    push(1'b0, 8'd0, 4'b0011, 8'd2, 8'd4);
    push(1'b0, 8'd0, 4'b0001, 8'd4, 8'd5);
    push(1'b0, 8'd0, 4'b0001, 8'd5, 8'd6);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    drained("s5_drained");
    chk("s5_fail_count", 32'(fail_count), 32'd6);
    chk("s5_pass_count", 32'(pass_count), 32'd0);

    // 6a: reset mid-flight discards the attempt.
    do_reset();
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("s6_cyc_after_rst", 32'(cyc), 32'd0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    drained("s6_drained");
    chk("s6_pass_count", 32'(pass_count), 32'd0);
    chk("s6_fail_count", 32'(fail_count), 32'd0);

    // 6b: fail_count saturates, and the timestamps wrap past 2^TW.
    do_reset();
    for (int k = 0; k < 260; k++) push(1'b0, 8'd0, 4'b0001, 8'(k), 8'(k + 1));
    repeat (260) step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    drained("sat_drained");
    chk("sat_fail_count", 32'(fail_count), 32'hFF);
    chk("sat_pass_count", 32'(pass_count), 32'd0);
    chk("wrap_cyc", 32'(cyc), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
